// File: rtl/main_mem_arb.sv
// Main memory arbiter: grants CPU/PPU req/ack accesses over the 22-bit NES logical
// address space, serves CPU-RAM/VRAM internally and forwards PRG/CHR/cart-RAM to the cart store.
module main_mem_arb #(
    parameter int DATA_WIDTH = 8,
    parameter int CPURAM_AW  = 11,
    parameter int VRAM_AW    = 11,
    parameter int ARB_MODE   = 0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  load_done,

    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [21:0]           cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_d,
    output logic                  cpu_ack,
    output logic [DATA_WIDTH-1:0] cpu_q,

    input  logic                  ppu_req,
    input  logic                  ppu_we,
    input  logic [21:0]           ppu_addr,
    input  logic [DATA_WIDTH-1:0] ppu_d,
    output logic                  ppu_ack,
    output logic [DATA_WIDTH-1:0] ppu_q,

    output logic                  cart_req,
    output logic                  cart_we,
    output logic [1:0]            cart_sel,
    output logic [20:0]           cart_addr,
    output logic [DATA_WIDTH-1:0] cart_d,
    input  logic                  cart_ack,
    input  logic [DATA_WIDTH-1:0] cart_q
);

    typedef enum logic [1:0] {IDLE, INT, CART, ACK} state_e;
    typedef enum logic [2:0] {R_PRG, R_CHR, R_VRAM, R_CPURAM, R_CARTRAM} region_e;

    function automatic region_e decodeRegion(input logic [3:0] top);
        region_e r;
        if (!top[3])      r = R_PRG;
        else if (!top[2]) r = R_CHR;
        else if (!top[1]) r = R_VRAM;
        else if (!top[0]) r = R_CPURAM;
        else              r = R_CARTRAM;
        return r;
    endfunction

    function automatic logic isInternal(input region_e r);
        return (r == R_VRAM) || (r == R_CPURAM);
    endfunction

    state_e                state_q, state_d;
    logic                  idPpu_q, we_q, lastPpu_q;
    logic [21:0]           addr_q;
    logic [DATA_WIDTH-1:0] d_q, rdData_q, cpuQ_q, ppuQ_q;

    logic [DATA_WIDTH-1:0] cpuRam [2**CPURAM_AW];
    logic [DATA_WIDTH-1:0] vram   [2**VRAM_AW];

    region_e cpuRegion, ppuRegion, grantRegion, latchedRegion;
    logic    cpuElig, ppuElig, grantValid, grantPpu, ackRead;

    assign cpuRegion     = decodeRegion(cpu_addr[21:18]);
    assign ppuRegion     = decodeRegion(ppu_addr[21:18]);
    assign latchedRegion = decodeRegion(addr_q[21:18]);

    // Cart-backed regions stay ineligible until the cart store has been loaded.
    assign cpuElig = cpu_req && (isInternal(cpuRegion) || load_done);
    assign ppuElig = ppu_req && (isInternal(ppuRegion) || load_done);

    always_comb begin
        grantPpu = ppuElig;
        if (cpuElig && ppuElig) begin
            grantPpu = (ARB_MODE == 0) ? 1'b1 : !lastPpu_q;
        end
    end

    assign grantValid  = cpuElig || ppuElig;
    assign grantRegion = grantPpu ? ppuRegion : cpuRegion;
    assign ackRead     = (state_q == ACK) && !we_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (grantValid) begin
                    state_d = isInternal(grantRegion) ? INT : CART;
                end
            end
            INT:  state_d = ACK;
            CART: begin
                if (cart_ack) begin
                    state_d = ACK;
                end
            end
            ACK:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            idPpu_q   <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            d_q       <= '0;
            lastPpu_q <= 1'b0;
            cpuQ_q    <= '0;
            ppuQ_q    <= '0;
        end else begin
            if (state_q == IDLE && grantValid) begin
                idPpu_q   <= grantPpu;
                we_q      <= grantPpu ? ppu_we   : cpu_we;
                addr_q    <= grantPpu ? ppu_addr : cpu_addr;
                d_q       <= grantPpu ? ppu_d    : cpu_d;
                lastPpu_q <= grantPpu;
            end
            if (ackRead && !idPpu_q) begin
                cpuQ_q <= rdData_q;
            end
            if (ackRead && idPpu_q) begin
                ppuQ_q <= rdData_q;
            end
        end
    end

    // RAM arrays carry no reset; rdData_q is shared by internal reads and cart returns.
    always_ff @(posedge clock) begin
        if (state_q == INT) begin
            if (latchedRegion == R_VRAM) begin
                if (we_q) begin
                    vram[addr_q[VRAM_AW-1:0]] <= d_q;
                end
                rdData_q <= vram[addr_q[VRAM_AW-1:0]];
            end else begin
                if (we_q) begin
                    cpuRam[addr_q[CPURAM_AW-1:0]] <= d_q;
                end
                rdData_q <= cpuRam[addr_q[CPURAM_AW-1:0]];
            end
        end else if (state_q == CART && cart_ack) begin
            rdData_q <= cart_q;
        end
    end

    always_comb begin
        cpu_ack   = (state_q == ACK) && !idPpu_q;
        ppu_ack   = (state_q == ACK) &&  idPpu_q;
        cpu_q     = (ackRead && !idPpu_q) ? rdData_q : cpuQ_q;
        ppu_q     = (ackRead &&  idPpu_q) ? rdData_q : ppuQ_q;
        cart_req  = 1'b0;
        cart_we   = 1'b0;
        cart_sel  = 2'b00;
        cart_addr = '0;
        cart_d    = '0;
        if (state_q == CART) begin
            cart_req = 1'b1;
            cart_we  = we_q;
            cart_d   = d_q;
            case (latchedRegion)
                R_PRG: begin
                    cart_sel  = 2'b01;
                    cart_addr = addr_q[20:0];
                end
                R_CHR: begin
                    cart_sel  = 2'b10;
                    cart_addr = {1'b0, addr_q[19:0]};
                end
                R_CARTRAM: begin
                    cart_sel  = 2'b11;
                    cart_addr = {3'b000, addr_q[17:0]};
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_main_mem_arb.sv
// Directed bench for main_mem_arb: table of single accesses plus hand-written
// sequences for arbitration ties, load_done gating and reset during a cart access.
module tb_main_mem_arb;

    logic        clock = 1'b0;
    logic        reset;
    logic        load_done;
    logic        cpu_req, cpu_we, ppu_req, ppu_we;
    logic [21:0] cpu_addr, ppu_addr;
    logic [7:0]  cpu_d, ppu_d;
    logic        cpu_ack, ppu_ack;
    logic [7:0]  cpu_q, ppu_q;
    logic        cart_req, cart_we, cart_ack;
    logic [1:0]  cart_sel;
    logic [20:0] cart_addr;
    logic [7:0]  cart_d, cart_q;

    logic        cpuAck1, ppuAck1, cartReq1, cartWe1;
    logic [7:0]  cpuQ1, ppuQ1, cartD1;
    logic [1:0]  cartSel1;
    logic [20:0] cartAddr1;

    int errorCount = 0;
    int checkCount = 0;

    typedef struct {
        string       name;
        bit          isPpu;
        bit          we;
        logic [21:0] addr;
        logic [7:0]  d;
        bit          isCart;
        int          cartLat;
        logic [7:0]  cartData;
        logic [1:0]  expSel;
        logic [20:0] expCartAddr;
        logic [7:0]  expQ;
        logic [7:0]  expOtherQ;
    } vec_t;

    vec_t vecs[10];

    always #5 clock = ~clock;

    main_mem_arb #(.DATA_WIDTH(8), .CPURAM_AW(11), .VRAM_AW(11), .ARB_MODE(0)) dut0 (
        .clock(clock), .reset(reset), .load_done(load_done),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_d(cpu_d),
        .cpu_ack(cpu_ack), .cpu_q(cpu_q),
        .ppu_req(ppu_req), .ppu_we(ppu_we), .ppu_addr(ppu_addr), .ppu_d(ppu_d),
        .ppu_ack(ppu_ack), .ppu_q(ppu_q),
        .cart_req(cart_req), .cart_we(cart_we), .cart_sel(cart_sel),
        .cart_addr(cart_addr), .cart_d(cart_d), .cart_ack(cart_ack), .cart_q(cart_q)
    );

    main_mem_arb #(.DATA_WIDTH(8), .CPURAM_AW(11), .VRAM_AW(11), .ARB_MODE(1)) dut1 (
        .clock(clock), .reset(reset), .load_done(load_done),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_d(cpu_d),
        .cpu_ack(cpuAck1), .cpu_q(cpuQ1),
        .ppu_req(ppu_req), .ppu_we(ppu_we), .ppu_addr(ppu_addr), .ppu_d(ppu_d),
        .ppu_ack(ppuAck1), .ppu_q(ppuQ1),
        .cart_req(cartReq1), .cart_we(cartWe1), .cart_sel(cartSel1),
        .cart_addr(cartAddr1), .cart_d(cartD1), .cart_ack(cart_ack), .cart_q(cart_q)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        logic [1:0] expAck;
        expAck = v.isPpu ? 2'b01 : 2'b10;
        @(negedge clock);
        if (v.isPpu) begin
            ppu_req = 1'b1; ppu_we = v.we; ppu_addr = v.addr; ppu_d = v.d;
        end else begin
            cpu_req = 1'b1; cpu_we = v.we; cpu_addr = v.addr; cpu_d = v.d;
        end
        @(negedge clock);
        if (!v.isCart) begin
            checkOutput({v.name, "/int-wait"}, {cpu_ack, ppu_ack, cart_req}, 3'b000);
            @(negedge clock);
        end else begin
            checkOutput({v.name, "/cart_req"}, cart_req, 1);
            checkOutput({v.name, "/cart_sel"}, cart_sel, v.expSel);
            checkOutput({v.name, "/cart_addr"}, cart_addr, v.expCartAddr);
            checkOutput({v.name, "/cart_we"}, cart_we, v.we);
            if (v.we) begin
                checkOutput({v.name, "/cart_d"}, cart_d, v.d);
            end
            for (int i = 0; i < v.cartLat; i++) begin
                @(negedge clock);
                checkOutput({v.name, "/cart-hold"},
                            {cart_req, cart_sel, cart_addr, cpu_ack, ppu_ack},
                            {1'b1, v.expSel, v.expCartAddr, 2'b00});
            end
            cart_ack = 1'b1;
            cart_q   = v.cartData;
            @(negedge clock);
            cart_ack = 1'b0;
            checkOutput({v.name, "/cart-drop"}, cart_req, 0);
        end
        checkOutput({v.name, "/ack"}, {cpu_ack, ppu_ack}, expAck);
        checkOutput({v.name, "/q"}, v.isPpu ? ppu_q : cpu_q, v.expQ);
        checkOutput({v.name, "/otherQ"}, v.isPpu ? cpu_q : ppu_q, v.expOtherQ);
        cpu_req = 1'b0;
        ppu_req = 1'b0;
        @(negedge clock);
        checkOutput({v.name, "/ack-pulse"}, {cpu_ack, ppu_ack}, 2'b00);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        vecs[0] = '{"cpuWrRam",     1'b0, 1'b1, 22'h380010, 8'h5A, 1'b0, 0, 8'h00, 2'b00, 21'h000000, 8'h00, 8'h00};
        vecs[1] = '{"cpuRdMirror",  1'b0, 1'b0, 22'h380810, 8'h00, 1'b0, 0, 8'h00, 2'b00, 21'h000000, 8'h5A, 8'h00};
        vecs[2] = '{"ppuWrVram",    1'b1, 1'b1, 22'h300004, 8'hC3, 1'b0, 0, 8'h00, 2'b00, 21'h000000, 8'h00, 8'h5A};
        vecs[3] = '{"ppuRdVramMir", 1'b1, 1'b0, 22'h340004, 8'h00, 1'b0, 0, 8'h00, 2'b00, 21'h000000, 8'hC3, 8'h5A};
        vecs[4] = '{"cpuRdVram",    1'b0, 1'b0, 22'h300004, 8'h00, 1'b0, 0, 8'h00, 2'b00, 21'h000000, 8'hC3, 8'hC3};
        vecs[5] = '{"ppuRdChr",     1'b1, 1'b0, 22'h200123, 8'h00, 1'b1, 4, 8'h77, 2'b10, 21'h000123, 8'h77, 8'hC3};
        vecs[6] = '{"cpuWrCartRam", 1'b0, 1'b1, 22'h3C0007, 8'h11, 1'b1, 2, 8'hEE, 2'b11, 21'h000007, 8'hC3, 8'h77};
        vecs[7] = '{"cpuRdPrg",     1'b0, 1'b0, 22'h1ABCDE, 8'h00, 1'b1, 1, 8'hE1, 2'b01, 21'h1ABCDE, 8'hE1, 8'h77};
        vecs[8] = '{"cpuWrRamTop",  1'b0, 1'b1, 22'h3807FF, 8'h99, 1'b0, 0, 8'h00, 2'b00, 21'h000000, 8'hE1, 8'h77};
        vecs[9] = '{"ppuRdRamTop",  1'b1, 1'b0, 22'h3807FF, 8'h00, 1'b0, 0, 8'h00, 2'b00, 21'h000000, 8'h99, 8'hE1};

        reset = 1'b1; load_done = 1'b0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_d = '0;
        ppu_req = 1'b0; ppu_we = 1'b0; ppu_addr = '0; ppu_d = '0;
        cart_ack = 1'b0; cart_q = '0;

        @(negedge clock);
        checkOutput("reset/ctrl0", {cpu_ack, ppu_ack, cart_req, cart_we, cart_sel}, 6'b0);
        checkOutput("reset/data0", {cpu_q, ppu_q, cart_d}, 24'h0);
        checkOutput("reset/addr0", cart_addr, 21'h0);
        checkOutput("reset/ctrl1", {cpuAck1, ppuAck1, cartReq1, cartWe1, cartSel1}, 6'b0);
        checkOutput("reset/data1", {cpuQ1, ppuQ1, cartD1, 3'b000, cartAddr1}, 48'h0);
        reset = 1'b0;
        load_done = 1'b1;

        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i]);
        end

        // Fixed-priority tie: PPU first, CPU re-arbitrates three cycles later.
        @(negedge clock);
        ppu_req = 1'b1; ppu_we = 1'b0; ppu_addr = 22'h380010;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 22'h3807FF;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clock);
            if (k == 2) begin
                checkOutput("tie0/ppuFirst", {cpu_ack, ppu_ack}, 2'b01);
                checkOutput("tie0/ppuQ", ppu_q, 8'h5A);
                ppu_req = 1'b0;
            end else if (k == 5) begin
                checkOutput("tie0/cpuSecond", {cpu_ack, ppu_ack}, 2'b10);
                checkOutput("tie0/cpuQ", cpu_q, 8'h99);
                cpu_req = 1'b0;
            end else begin
                checkOutput("tie0/gap", {cpu_ack, ppu_ack}, 2'b00);
            end
        end

        // load_done low: PRG request waits while VRAM traffic proceeds.
        @(negedge clock);
        load_done = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 22'h001000;
        ppu_req = 1'b1; ppu_we = 1'b0; ppu_addr = 22'h300004;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clock);
            checkOutput("gate/noCart", {cart_req, cpu_ack}, 2'b00);
            if (k == 2) begin
                checkOutput("gate/ppuAck", ppu_ack, 1);
                checkOutput("gate/ppuQ", ppu_q, 8'hC3);
                ppu_req = 1'b0;
            end
        end
        load_done = 1'b1;
        @(negedge clock);
        checkOutput("gate/cartReq", {cart_req, cart_sel, cart_addr, cpu_ack}, {1'b1, 2'b01, 21'h001000, 1'b0});
        cart_ack = 1'b1; cart_q = 8'h3D;
        @(negedge clock);
        cart_ack = 1'b0;
        checkOutput("gate/cpuAck", cpu_ack, 1);
        checkOutput("gate/cpuQ", cpu_q, 8'h3D);
        cpu_req = 1'b0;

        // Reset while the cart access is outstanding.
        @(negedge clock);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 22'h012345;
        @(negedge clock);
        checkOutput("rstCart/reqUp", cart_req, 1);
        @(negedge clock);
        reset = 1'b1;
        cpu_req = 1'b0;
        #1;
        checkOutput("rstCart/immediate", {cart_req, cpu_ack, ppu_ack, cart_sel}, 5'b0);
        checkOutput("rstCart/qZero", {cpu_q, ppu_q}, 16'h0);
        checkOutput("rstCart/addrZero", cart_addr, 21'h0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        cart_ack = 1'b1; cart_q = 8'h55;
        @(negedge clock);
        cart_ack = 1'b0;
        checkOutput("rstCart/lateAck", {cart_req, cpu_ack, ppu_ack}, 3'b000);
        checkOutput("rstCart/qStill", cpu_q, 8'h00);
        @(negedge clock);
        checkOutput("rstCart/lateAck2", {cart_req, cpu_ack, ppu_ack}, 3'b000);

        // Repeated ties with both requests held: fixed priority vs round-robin.
        @(negedge clock);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 22'h3807FF;
        ppu_req = 1'b1; ppu_we = 1'b0; ppu_addr = 22'h380010;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clock);
            checkOutput($sformatf("tieFixed/k%0d", k), {cpu_ack, ppu_ack},
                        (k % 3 == 2) ? 2'b01 : 2'b00);
            checkOutput($sformatf("tieRr/k%0d", k), {cpuAck1, ppuAck1},
                        (k == 2 || k == 8) ? 2'b01 : ((k == 5) ? 2'b10 : 2'b00));
        end
        cpu_req = 1'b0;
        ppu_req = 1'b0;
        @(negedge clock);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
